rom_port_arbiter: RTL and testbench
===================================

# rom_port_arbiter

Shares the single image-ROM read port (`memoryRead`, 1-cycle registered read) between the background renderer and the other pixel sources: fruit sprites, blade trail and score digits. Port 0 belongs to the background display path and has strict priority. Ports 1..N_PORTS-1 share the remaining cycles round-robin. Each returned word carries the id of the port that requested it, so the sprite and overlay units can run from one ROM without knowing about each other.

## Interface
Parameters:
- `N_PORTS`, 4: number of requesters (≥2); port 0 is the video port.
- `ADDR_W`, 19: ROM address width (matches memory_depth_base).
- `DATA_W`, 12: pixel width, RGB444.
- `ID_W`, $clog2(N_PORTS): response tag width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system/pixel clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N_PORTS  per-port read request.
- `addr`  in  N_PORTS*ADDR_W  per-port absolute ROM address; port i occupies bits [i*ADDR_W +: ADDR_W].
- `gnt`  out  N_PORTS  one-hot combinational grant; acceptance happens in the cycle req_i && gnt_i.
- `rom_addr`  out  ADDR_W  registered address to memoryRead.
- `rom_en`  out  1  registered; 1 when rom_addr holds a granted request.
- `rom_data`  in  DATA_W  memoryRead output.
- `rsp_valid`  out  1  response word valid.
- `rsp_id`  out  ID_W  port the response belongs to.
- `rsp_data`  out  DATA_W  equals rom_data, passed through combinationally.

## Operation
- Arbitration is evaluated every cycle from the current `req`:
  - If req[0]=1, gnt[0]=1. Port 0 always wins.
  - Otherwise, the lowest-index requesting port at or after `rr_ptr` (range 1..N_PORTS-1, wrapping to 1) wins.
  - If no port requests, gnt is all zero.
- `rr_ptr` updates only on a port ≥1 grant, to winner+1. It wraps to 1 after N_PORTS-1 and never points at 0. A port-0 grant leaves it unchanged.
- At most one gnt bit is set in any cycle. gnt_i=1 implies req_i=1.
- On acceptance, the winner's addr is registered into `rom_addr` with `rom_en`=1, and its id enters the response pipeline.
- With no grant: `rom_en`=0, `rom_addr` holds its last value, and a bubble enters the pipeline.
- A requester keeps req and addr stable until granted. It may drop req or change addr freely after the accept cycle. Back-to-back requests from the same port are legal.
- Responses are never stalled: there is no ready on the response side, and consumers must accept every rsp_valid for their id.
- Reset values: rr_ptr=1, rom_addr=0, rom_en=0, both id/valid pipeline stages cleared, so rsp_valid=0 and rsp_id=0.
- Reset mid-operation: all in-flight responses are squashed, and no rsp_valid is issued for requests accepted before rst.
- Boundary cases:
  - With N_PORTS=2 the round-robin has a single member, and port 1 gets every cycle port 0 leaves idle.
  - Addresses are passed unmodified; no range check or wrap is applied.

## Timing
- Cycle t: req_i=1 and gnt_i=1 (accept).
- t+1: rom_addr = addr_i, rom_en=1.
- t+2: rom_data valid; rsp_valid=1, rsp_id=i, rsp_data=ROM[addr_i].
- Fixed latency: 2 cycles from accept to response.
- Throughput: one accept per cycle. Responses return in accept order.
- gnt is a combinational path from req through the picker. All other outputs except rsp_data are registered.

## Structure
- Shared package `fn_mem_pkg` holds:
  - ADDR_W and DATA_W, also used by displayBg and the sprite units;
  - a localparam for the ROM read latency (1);
  - the port-index constants PORT_BG=0, PORT_FRUIT=1, PORT_TRAIL=2, PORT_SCORE=3.
- Sub-module `rr_pick`: a purely combinational round-robin picker with inputs req[N-1:1] and ptr, and outputs a one-hot grant and the winner index. The top level adds the port-0 override, the address mux, rr_ptr and the 2-stage id/valid shift register.

## Test plan
- **Reset:** assert rst for 3 cycles with req=4'b1111.
  - Expect gnt=4'b0001 combinationally.
  - Expect rom_en=0 and rsp_valid=0 throughout reset.
  - Expect the first rsp_valid exactly 2 cycles after rst falls, with rsp_id=0.
- **Port-0 priority:** hold req=4'b1111 for 6 cycles with addr0=19'h00100.
  - Expect gnt=0001 every cycle.
  - Expect rsp_id=0 every cycle from t+2.
  - Expect rr_ptr to stay at 1.
- **Round-robin:** req=4'b1110 continuously.
  - Expect the grant sequence 0010, 0100, 1000, 0010, …
  - Expect rsp_id 1, 2, 3, 1, … each 2 cycles later, with rsp_data matching the preloaded ROM.
- **Interleave:** port 0 requests on alternate cycles, ports 1–3 request continuously.
  - Expect port-0 grants on its request cycles.
  - Expect the gap cycles to rotate 1→2→3 with no port skipped.
- **Idle bubble:** a single accept on port 2 (addr=19'h04B00), then req=0.
  - Expect rom_en=1 for one cycle, then rom_addr held at 19'h04B00 with rom_en=0.
  - Expect one rsp_valid with id=2.
- **Reset mid-flight:** accept on port 1 at t, assert rst at t+1.
  - Expect no rsp_valid at t+2.
  - Expect rr_ptr=1 after reset.

Source files
------------

// File: rtl/fn_mem_pkg.sv
// Shared image-ROM constants: geometry, read latency and the fixed
// port assignment used by the background, sprite and overlay units.
package fn_mem_pkg;

  localparam int ADDR_W     = 19;
  localparam int DATA_W     = 12;
  localparam int ROM_RD_LAT = 1;

  localparam int PORT_BG    = 0;
  localparam int PORT_FRUIT = 1;
  localparam int PORT_TRAIL = 2;
  localparam int PORT_SCORE = 3;

  typedef logic [ADDR_W-1:0] rom_addr_t;
  typedef logic [DATA_W-1:0] pixel_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker over ports 1..N-1: the first requester
// at or after ptr wins, wrapping from N-1 back to 1.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:1]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:1]  gnt,
  output logic [PW-1:0] winner
);

  int   idx;
  logic found;

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 1;
    for (int k = 0; k < N - 1; k++) begin
      // Offset keeps the modulo operand non-negative even for an illegal ptr of 0.
      idx = ((int'(ptr) + N - 2 + k) % (N - 1)) + 1;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        winner   = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the single registered-read image ROM between the video port (0,
// strict priority) and round-robin overlay ports, tagging each response.
module rom_port_arbiter #(
  parameter int N_PORTS = 4,
  parameter int ADDR_W  = fn_mem_pkg::ADDR_W,
  parameter int DATA_W  = fn_mem_pkg::DATA_W,
  parameter int ID_W    = $clog2(N_PORTS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS-1:0]        req,
  input  logic [N_PORTS*ADDR_W-1:0] addr,
  output logic [N_PORTS-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_addr,
  output logic                      rom_en,
  input  logic [DATA_W-1:0]         rom_data,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data
);

  localparam logic [ID_W-1:0] BG_ID    = ID_W'(fn_mem_pkg::PORT_BG);
  localparam logic [ID_W-1:0] FIRST_RR = ID_W'(1);
  localparam logic [ID_W-1:0] LAST_RR  = ID_W'(N_PORTS - 1);

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    rr_win;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    id_s1;
  logic [N_PORTS-1:1] rr_gnt;
  logic               accept;

  rr_pick #(
    .N  (N_PORTS),
    .PW (ID_W)
  ) u_pick (
    .req    (req[N_PORTS-1:1]),
    .ptr    (rr_ptr),
    .gnt    (rr_gnt),
    .winner (rr_win)
  );

  always_comb begin
    gnt    = '0;
    win_id = rr_win;
    if (req[0]) begin
      gnt[0] = 1'b1;
      win_id = BG_ID;
    end else begin
      gnt[N_PORTS-1:1] = rr_gnt;
    end
  end

  assign accept   = |gnt;
  assign rsp_data = rom_data;

  // rom_en doubles as the stage-1 valid bit; rsp_valid/rsp_id are stage 2,
  // aligned with the cycle the ROM drives its data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= FIRST_RR;
      rom_addr  <= '0;
      rom_en    <= 1'b0;
      id_s1     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      rom_en <= accept;
      if (accept) begin
        rom_addr <= addr[int'(win_id)*ADDR_W +: ADDR_W];
      end
      if (accept && !req[0]) begin
        rr_ptr <= (rr_win == LAST_RR) ? FIRST_RR : rr_win + FIRST_RR;
      end
      id_s1     <= accept ? win_id : BG_ID;
      rsp_valid <= rom_en;
      rsp_id    <= id_s1;
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Randomised scoreboard bench for rom_port_arbiter with a behavioural
// arbitration model and a simple registered-read ROM.
module tb_rom_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 19;
  localparam int DW = 12;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req;
  logic [N*AW-1:0]   addr;
  logic [N-1:0]      gnt;
  logic [AW-1:0]     rom_addr;
  logic              rom_en;
  logic [DW-1:0]     rom_data;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [DW-1:0]     rsp_data;

  exp_t          sb[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;

  int            m_ptr = 1;
  logic          m_en = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [N-1:0]  pend = '0;
  logic [AW-1:0] hold [N];
  logic [AW-1:0] w_addr [N];

  rom_port_arbiter #(
    .N_PORTS (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .ID_W    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .addr      (addr),
    .gnt       (gnt),
    .rom_addr  (rom_addr),
    .rom_en    (rom_en),
    .rom_data  (rom_data),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return a[11:0] ^ {a[18:12], 5'b0} ^ 12'h5A3;
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  // Priority rule: port 0 first, then ports p..N-1, then 1..p-1.
  function automatic int ref_pick(input logic [N-1:0] r, input int p);
    if (r[0]) return 0;
    for (int i = p; i < N; i++) if (r[i]) return i;
    for (int i = 1; i < p; i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: ports still waiting keep req/addr; others take the wish.
  task automatic step(input bit r, input logic [N-1:0] want);
    logic [N-1:0] rq;
    logic [N-1:0] eg;
    int           w;
    @(posedge clk);
    #1;
    rq = want | pend;
    for (int i = 0; i < N; i++) begin
      if (!pend[i]) hold[i] = w_addr[i];
      addr[i*AW +: AW] = hold[i];
    end
    rst = r;
    req = rq;
    w   = ref_pick(rq, m_ptr);
    eg  = '0;
    if (w >= 0) eg[w] = 1'b1;
    @(negedge clk);
    check("gnt", 32'(gnt), 32'(eg));
    check("rom_en", 32'(rom_en), 32'(m_en));
    check("rom_addr", 32'(rom_addr), 32'(m_addr));
    if (r) begin
      m_ptr  = 1;
      m_en   = 1'b0;
      m_addr = '0;
      pend   = '0;
      while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
    end else begin
      m_en = (w >= 0);
      pend = rq;
      if (w >= 0) begin
        m_addr  = hold[w];
        pend[w] = 1'b0;
        sb.push_back('{id: w, data: rom_fn(hold[w]), due: cyc + 2});
        if (w > 0) m_ptr = (w == N - 1) ? 1 : w + 1;
      end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && pend != '0; k++) step(1'b0, '0);
    check("drained", 32'(pend), 32'd0);
  endtask

  // Monitor: a response is due exactly when the scoreboard head says so.
  initial begin : monitor
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        if (rsp_valid === 1'b1) begin
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_data", 32'(rsp_data), 32'(e.data));
        end
      end else begin
        check("no_rsp", 32'(rsp_valid), 32'd0);
      end
    end
  end

  initial begin : driver
    rst  = 1'b1;
    req  = 4'b1111;
    addr = '0;
    for (int i = 0; i < N; i++) begin
      w_addr[i] = '0;
      hold[i]   = '0;
    end

    repeat (3) step(1'b1, 4'b1111);

    w_addr[0] = 19'h00100;
    w_addr[1] = 19'h11111;
    w_addr[2] = 19'h22222;
    w_addr[3] = 19'h33333;
    repeat (6) step(1'b0, 4'b1111);

    for (int k = 0; k < 9; k++) begin
      for (int i = 1; i < N; i++) w_addr[i] = AW'($urandom);
      step(1'b0, 4'b1110);
    end

    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < N; i++) w_addr[i] = AW'($urandom);
      step(1'b0, {3'b111, (k % 2 == 0)});
    end

    drain();
    w_addr[2] = 19'h04B00;
    step(1'b0, 4'b0100);
    repeat (4) step(1'b0, 4'b0000);

    drain();
    w_addr[1] = 19'h01234;
    step(1'b0, 4'b0010);
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0000);
    for (int i = 1; i < N; i++) w_addr[i] = AW'($urandom);
    step(1'b0, 4'b1110);
    repeat (3) step(1'b0, 4'b0000);

    for (int k = 0; k < 400; k++) begin
      logic [N-1:0] want;
      for (int i = 0; i < N; i++) w_addr[i] = AW'($urandom);
      want    = 4'($urandom_range(0, 15));
      want[0] = ($urandom_range(0, 3) == 0);
      step(($urandom_range(0, 59) == 0), want);
    end

    repeat (4) step(1'b0, 4'b0000);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
